// File: rtl/mole_game_controller.sv
// Whack-a-mole sequencing FSM: round arming, LFSR mole placement, whack
// detection on switch toggles, score keeping and the seconds countdown.

// One switch lane: registers the switch and flags any change as a toggle.
// No reset on purpose: the first clock after release loads the live switch value.
module mole_sw_toggle (
  input  logic clk,
  input  logic sw_bit,
  output logic toggle
);
  logic sw_q;

  always_ff @(posedge clk) sw_q <= sw_bit;

  assign toggle = sw_bit ^ sw_q;
endmodule

module mole_game_controller #(
  parameter int          MOLE_CYCLES  = 75000000,
  parameter int          GAME_SECONDS = 30,
  parameter int          MAX_SCORE    = 99,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] sw,
  input  logic        sec_tick,
  output logic [15:0] LED,
  output logic [7:0]  timer_count,
  output logic [7:0]  score_count,
  output logic        playing,
  output logic        game_over
);
  localparam int NUM_LANES = 16;
  localparam int CNT_W     = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SPAWN, UP, OVER} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr;
  logic                 start_q;
  logic [3:0]           mole_idx;
  logic [CNT_W-1:0]     mole_cnt;
  logic [NUM_LANES-1:0] toggles;
  logic [3:0]           cand;
  logic                 start_rise, in_round, hit, timeout, last_tick, reload;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mole_sw_toggle u_tog (
      .clk    (clk),
      .sw_bit (sw[g]),
      .toggle (toggles[g])
    );
  end

  assign start_rise = start & ~start_q;
  assign in_round   = (state_q == SPAWN) || (state_q == UP);
  assign hit        = (state_q == UP) && toggles[mole_idx];
  assign timeout    = (state_q == UP) && (mole_cnt == '0);
  assign last_tick  = in_round && sec_tick && (timer_count == 8'd1);
  assign reload     = ((state_q == IDLE) || (state_q == OVER)) && start_rise;
  assign cand       = lfsr[3:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; the final second ends the round even over a same-cycle hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = SPAWN;
      SPAWN:   state_d = UP;
      UP:      if (hit || timeout) state_d = SPAWN;
      OVER:    if (start_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (last_tick) state_d = OVER;
  end

  // Outputs decoded from state
  always_comb begin
    LED       = '0;
    playing   = 1'b0;
    game_over = 1'b0;
    case (state_q)
      SPAWN:   playing = 1'b1;
      UP: begin
        playing = 1'b1;
        LED     = 16'd1 << mole_idx;
      end
      OVER:    game_over = 1'b1;
      default: ;
    endcase
  end

  // Datapath: LFSR (taps 16,14,13,11), mole position/dwell, timer and score
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr        <= LFSR_SEED;
      start_q     <= 1'b0;
      mole_idx    <= '0;
      mole_cnt    <= '0;
      timer_count <= 8'(GAME_SECONDS);
      score_count <= '0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start_q <= start;

      if (state_q == SPAWN) begin
        // Bump a repeated position so the mole always visibly moves
        mole_idx <= (cand == mole_idx) ? cand + 4'd1 : cand;
        mole_cnt <= CNT_W'(MOLE_CYCLES - 1);
      end else if (state_q == UP && mole_cnt != '0) begin
        mole_cnt <= mole_cnt - 1'b1;
      end

      if (reload)                                            timer_count <= 8'(GAME_SECONDS);
      else if (in_round && sec_tick && timer_count > 8'd1)   timer_count <= timer_count - 8'd1;
      else if (last_tick)                                    timer_count <= '0;

      if (reload)                                            score_count <= '0;
      else if (hit && score_count < 8'(MAX_SCORE))           score_count <= score_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_mole_game_controller.sv
// Bench for mole_game_controller: a cycle model feeds an expected-output
// queue checked at each falling edge, plus table rows and hand sequences.
module tb_mole_game_controller;
  localparam int          MC   = 10;
  localparam int          GS   = 3;
  localparam int          MS   = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] sw;
  logic        sec_tick;
  logic [15:0] LED;
  logic [7:0]  timer_count, score_count;
  logic        playing, game_over;

  mole_game_controller #(
    .MOLE_CYCLES (MC), .GAME_SECONDS (GS), .MAX_SCORE (MS), .LFSR_SEED (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sw          (sw),
    .sec_tick    (sec_tick),
    .LED         (LED),
    .timer_count (timer_count),
    .score_count (score_count),
    .playing     (playing),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] led;
    logic [7:0]  timer;
    logic [7:0]  score;
    logic        playing;
    logic        over;
  } exp_t;

  typedef struct {
    logic st;
    logic tk;
    int   act;      // 0 idle, 1 hit, 2 miss, 3 hit when the mole is up
    int   n;
    int   e_timer;
    int   e_score;
    logic e_over;
  } vec_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state (0 IDLE, 1 SPAWN, 2 UP, 3 OVER)
  int          m_state, m_cnt, m_timer, m_score;
  logic [15:0] m_lfsr, m_swq;
  logic [3:0]  m_idx;
  logic        m_startq;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, req, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_lfsr = SEED; m_idx = 4'd0; m_cnt = 0;
    m_timer = GS; m_score = 0; m_swq = sw; m_startq = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs
  task automatic step(input logic st, input logic [15:0] s, input logic tk);
    logic [15:0] tog;
    logic        rise;
    logic [3:0]  c;
    int          ns;
    exp_t        e;
    start = st; sw = s; sec_tick = tk;
    tog  = s ^ m_swq;
    rise = st & ~m_startq;
    ns   = m_state;
    case (m_state)
      0: if (rise) begin m_score = 0; m_timer = GS; ns = 1; end
      1: begin
        c = m_lfsr[3:0];
        m_idx = (c == m_idx) ? c + 4'd1 : c;
        m_cnt = MC - 1;
        ns = 2;
      end
      2: begin
        if (tog[m_idx]) begin
          if (m_score < MS) m_score++;
          ns = 1;
        end else if (m_cnt == 0) ns = 1;
        else m_cnt--;
      end
      default: if (rise) begin ns = 0; m_timer = GS; m_score = 0; end
    endcase
    if ((m_state == 1 || m_state == 2) && tk) begin
      if (m_timer > 1) m_timer--;
      else if (m_timer == 1) begin m_timer = 0; ns = 3; end
    end
    m_state  = ns;
    m_lfsr   = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_swq    = s;
    m_startq = st;
    e.led     = (m_state == 2) ? (16'd1 << m_idx) : 16'd0;
    e.timer   = 8'(m_timer);
    e.score   = 8'(m_score);
    e.playing = (m_state == 1 || m_state == 2);
    e.over    = (m_state == 3);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led",       int'(LED),         int'(e.led));
      chk("timer",     int'(timer_count), int'(e.timer));
      chk("score",     int'(score_count), int'(e.score));
      chk("playing",   int'(playing),     int'(e.playing));
      chk("game_over", int'(game_over),   int'(e.over));
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_led"},     int'(LED),         0);
    chk({tag, "_timer"},   int'(timer_count), GS);
    chk({tag, "_score"},   int'(score_count), 0);
    chk({tag, "_playing"}, int'(playing),     0);
    chk({tag, "_over"},    int'(game_over),   0);
  endtask

  initial begin
    vec_t        vec[18];
    logic [15:0] s;
    logic [15:0] one = 16'd1;

    vec[0]  = '{1'b1, 1'b0, 0, 1,  3, 0, 1'b0};  // start -> SPAWN
    vec[1]  = '{1'b0, 1'b0, 0, 1,  3, 0, 1'b0};  // first mole up
    vec[2]  = '{1'b0, 1'b0, 0, 10, 3, 0, 1'b0};  // dwell expires -> SPAWN
    vec[3]  = '{1'b0, 1'b0, 0, 1,  3, 0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1, 1,  3, 1, 1'b0};  // hit
    vec[5]  = '{1'b0, 1'b0, 0, 1,  3, 1, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 2, 1,  3, 1, 1'b0};  // miss
    vec[7]  = '{1'b0, 1'b1, 0, 1,  2, 1, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 0, 1,  1, 1, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 1, 1,  0, 2, 1'b1};  // hit on the final tick
    vec[10] = '{1'b0, 1'b1, 2, 2,  0, 2, 1'b1};  // ignored in OVER
    vec[11] = '{1'b1, 1'b0, 0, 1,  3, 0, 1'b0};  // OVER -> IDLE
    vec[12] = '{1'b0, 1'b1, 0, 1,  3, 0, 1'b0};  // tick ignored in IDLE
    vec[13] = '{1'b1, 1'b0, 0, 1,  3, 0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 0, 1,  3, 0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 3, 14, 3, 5, 1'b0};  // seven hits saturate
    vec[16] = '{1'b1, 1'b0, 0, 1,  3, 5, 1'b0};  // no restart mid-round
    vec[17] = '{1'b0, 1'b0, 0, 1,  3, 5, 1'b0};

    reset = 1'b0; start = 1'b0; sec_tick = 1'b0; sw = 16'h5A3C;
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals("rst");
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < vec[i].n; k++) begin
        s = sw;
        case (vec[i].act)
          1: s = sw ^ (one << m_idx);
          2: s = sw ^ (one << (m_idx + 4'd3));
          3: if (m_state == 2) s = sw ^ (one << m_idx);
          default: ;
        endcase
        step(vec[i].st, s, vec[i].tk);
      end
      chk($sformatf("vec%0d_timer", i), int'(timer_count), vec[i].e_timer);
      chk($sformatf("vec%0d_score", i), int'(score_count), vec[i].e_score);
      chk($sformatf("vec%0d_over",  i), int'(game_over),   int'(vec[i].e_over));
    end

    // Reset in the middle of a round
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Fresh round: first mole two cycles after start, then run out the clock
    step(1'b1, sw, 1'b0);
    step(1'b0, sw, 1'b0);
    chk("first_led_onehot", $countones(LED), 1);
    chk("first_timer", int'(timer_count), GS);
    for (int k = 0; k < GS; k++) step(1'b0, sw, 1'b1);
    chk("end_over",  int'(game_over),   1);
    chk("end_led",   int'(LED),         0);
    chk("end_timer", int'(timer_count), 0);
    for (int k = 0; k < 2; k++) step(1'b0, ~sw, 1'b1);
    chk("over_hold_timer", int'(timer_count), 0);
    chk("over_hold_score", int'(score_count), 0);
    chk("over_hold_over",  int'(game_over),   1);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
